// File: rtl/ov7670_pkg.sv
// rtl/ov7670_pkg.sv - shared state encoding, default timing and RGB565 byte split for the OV7670 emulator
package ov7670_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_VSYNC   = 3'd1,
        ST_V_BACK  = 3'd2,
        ST_ACTIVE  = 3'd3,
        ST_V_FRONT = 3'd4
    } state_t;

    localparam int DEF_H_BLANK  = 144;
    localparam int DEF_VS_LINES = 3;
    localparam int DEF_V_BACK   = 17;
    localparam int DEF_V_FRONT  = 10;

    // Camera sends the high byte {R,G[5:3]} first, then {G[2:0],B}.
    function automatic logic [7:0] rgb565_byte(input logic [15:0] px, input logic second);
        return second ? px[7:0] : px[15:8];
    endfunction

endpackage

// File: rtl/ov7670_tx_timing.sv
// rtl/ov7670_tx_timing.sv - PCLK phase, tick and line counters with line-end and fetch-point strobes
module ov7670_tx_timing #(
    parameter int H_WIDTH = 320,
    parameter int H_BLANK = 144,
    parameter int HCW     = 10,
    parameter int LCW     = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           run,
    input  logic           line_clr,
    output logic           phase,
    output logic [HCW-1:0] h_cnt,
    output logic [LCW-1:0] line_cnt,
    output logic           tick_end,
    output logic           line_end,
    output logic           pix_fetch,
    output logic           line_fetch
);
    localparam int LAST = 2*H_WIDTH + H_BLANK - 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase    <= 1'b0;
            h_cnt    <= '0;
            line_cnt <= '0;
        end else begin
            phase <= ~phase;
            if (!run) begin
                h_cnt    <= '0;
                line_cnt <= '0;
            end else begin
                if (phase)
                    h_cnt <= (h_cnt == HCW'(LAST)) ? '0 : h_cnt + 1'b1;
                if (line_clr)
                    line_cnt <= '0;
                else if (line_end)
                    line_cnt <= line_cnt + 1'b1;
            end
        end
    end

    // Strobes mark the last (phase-1) cycle of a tick, so registered outputs land on the falling PCLK.
    assign tick_end   = phase;
    assign line_end   = phase && (h_cnt == HCW'(LAST));
    assign pix_fetch  = phase && !h_cnt[0] && (h_cnt <= HCW'(2*H_WIDTH - 4));
    assign line_fetch = phase && (h_cnt == HCW'(LAST - 1));

endmodule

// File: rtl/ov7670_sensor_emulator.sv
// rtl/ov7670_sensor_emulator.sv - OV7670 camera-side emulator driving QVGA RGB565 from a frame BRAM
module ov7670_sensor_emulator
    import ov7670_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int H_WIDTH    = 320,
    parameter int V_WIDTH    = 240,
    parameter int R_WIDTH    = 5,
    parameter int G_WIDTH    = 6,
    parameter int B_WIDTH    = 5,
    parameter int PXL_WIDTH  = R_WIDTH + G_WIDTH + B_WIDTH,
    parameter int H_BLANK    = DEF_H_BLANK,
    parameter int VS_LINES   = DEF_VS_LINES,
    parameter int V_BACK     = DEF_V_BACK,
    parameter int V_FRONT    = DEF_V_FRONT
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_enable,
    output logic [2:0]                o_present_state,
    output logic                      o_frame_done,
    output logic                      o_PCLK,
    output logic                      o_VS,
    output logic                      o_HS,
    output logic [DATA_WIDTH-1:0]     o_DATA,
    output logic                      o_rd_en,
    output logic [$clog2(H_WIDTH):0]  o_h_addr,
    output logic [$clog2(V_WIDTH):0]  o_v_addr,
    input  logic [PXL_WIDTH-1:0]      i_pixel_data
);
    localparam int LINE_TICKS = 2*H_WIDTH + H_BLANK;
    localparam int HCW = $clog2(LINE_TICKS);
    localparam int LCW = $clog2(VS_LINES + V_BACK + V_WIDTH + V_FRONT);
    localparam int HAW = $clog2(H_WIDTH) + 1;
    localparam int VAW = $clog2(V_WIDTH) + 1;

    state_t         state, state_n;
    logic           phase, tick_end, line_end, pix_fetch, line_fetch;
    logic [HCW-1:0] h_cnt, h_nxt;
    logic [LCW-1:0] line_cnt;
    logic [7:0]     lo_byte;
    logic [15:0]    px;

    assign px = 16'(i_pixel_data);

    ov7670_tx_timing #(
        .H_WIDTH (H_WIDTH),
        .H_BLANK (H_BLANK),
        .HCW     (HCW),
        .LCW     (LCW)
    ) u_timing (
        .clk        (i_clk),
        .reset      (i_reset),
        .run        (state != ST_IDLE),
        .line_clr   (state_n != state),
        .phase      (phase),
        .h_cnt      (h_cnt),
        .line_cnt   (line_cnt),
        .tick_end   (tick_end),
        .line_end   (line_end),
        .pix_fetch  (pix_fetch),
        .line_fetch (line_fetch)
    );

    always_comb begin
        state_n = state;
        h_nxt   = (h_cnt == HCW'(LINE_TICKS - 1)) ? '0 : h_cnt + 1'b1;
        case (state)
            ST_IDLE:    if (tick_end && i_enable) state_n = ST_VSYNC;
            ST_VSYNC:   if (line_end && line_cnt == LCW'(VS_LINES - 1)) state_n = ST_V_BACK;
            ST_V_BACK:  if (line_end && line_cnt == LCW'(V_BACK - 1))   state_n = ST_ACTIVE;
            ST_ACTIVE:  if (line_end && line_cnt == LCW'(V_WIDTH - 1))  state_n = ST_V_FRONT;
            ST_V_FRONT: if (line_end && line_cnt == LCW'(V_FRONT - 1))
                            state_n = i_enable ? ST_VSYNC : ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end

    // All pin outputs are computed for the upcoming tick and registered at its falling PCLK.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= ST_IDLE;
            o_VS         <= 1'b0;
            o_HS         <= 1'b0;
            o_DATA       <= '0;
            o_rd_en      <= 1'b0;
            o_h_addr     <= '0;
            o_v_addr     <= '0;
            o_frame_done <= 1'b0;
            lo_byte      <= '0;
        end else begin
            o_rd_en      <= 1'b0;
            o_frame_done <= 1'b0;
            if (tick_end) begin
                state        <= state_n;
                o_VS         <= (state_n == ST_VSYNC);
                o_frame_done <= (state == ST_V_FRONT) && (state_n != ST_V_FRONT);
                if (state_n == ST_ACTIVE && h_nxt < HCW'(2*H_WIDTH)) begin
                    o_HS <= 1'b1;
                    if (h_nxt[0]) begin
                        o_DATA <= DATA_WIDTH'(lo_byte);
                    end else begin
                        o_DATA  <= DATA_WIDTH'(rgb565_byte(px, 1'b0));
                        lo_byte <= rgb565_byte(px, 1'b1);
                    end
                end else begin
                    o_HS   <= 1'b0;
                    o_DATA <= '0;
                end
                // Pixel 0 of a row is fetched in the last tick of the preceding line.
                if (state == ST_ACTIVE && pix_fetch) begin
                    o_rd_en  <= 1'b1;
                    o_h_addr <= HAW'(h_cnt[HCW-1:1]) + 1'b1;
                    o_v_addr <= VAW'(line_cnt);
                end else if (line_fetch &&
                             ((state == ST_V_BACK && line_cnt == LCW'(V_BACK - 1)) ||
                              (state == ST_ACTIVE && line_cnt != LCW'(V_WIDTH - 1)))) begin
                    o_rd_en  <= 1'b1;
                    o_h_addr <= '0;
                    o_v_addr <= (state == ST_ACTIVE) ? VAW'(line_cnt) + 1'b1 : '0;
                end
            end
        end
    end

    assign o_PCLK          = phase;
    assign o_present_state = state;

endmodule

// File: tb/tb_ov7670_sensor_emulator.sv
// tb/tb_ov7670_sensor_emulator.sv - directed self-checking bench for the OV7670 sensor emulator
module tb_ov7670_sensor_emulator;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic [2:0]  state;
    logic        frame_done, pclk, vs, hs, rd_en;
    logic [7:0]  data;
    logic [2:0]  h_addr, v_addr;
    logic [15:0] pixel_data;

    int n_tests = 0;
    int n_fail  = 0;

    ov7670_sensor_emulator #(
        .DATA_WIDTH (8),
        .H_WIDTH    (4),
        .V_WIDTH    (3),
        .H_BLANK    (4),
        .VS_LINES   (1),
        .V_BACK     (1),
        .V_FRONT    (1)
    ) dut (
        .i_clk           (clk),
        .i_reset         (i_reset),
        .i_enable        (i_enable),
        .o_present_state (state),
        .o_frame_done    (frame_done),
        .o_PCLK          (pclk),
        .o_VS            (vs),
        .o_HS            (hs),
        .o_DATA          (data),
        .o_rd_en         (rd_en),
        .o_h_addr        (h_addr),
        .o_v_addr        (v_addr),
        .i_pixel_data    (pixel_data)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk)
        if (rd_en) pixel_data <= 16'hA0B0 + {10'd0, v_addr, h_addr};

    task automatic test_reset();
        logic exp_pclk;
        i_reset  = 1'b1;
        i_enable = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({pclk, frame_done, vs, hs, data, rd_en, h_addr, v_addr, state} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_values got %h want 0",
                     {pclk, frame_done, vs, hs, data, rd_en, h_addr, v_addr, state});
        end
        i_reset  = 1'b0;
        exp_pclk = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n_tests++;
            if (pclk !== exp_pclk) begin
                n_fail++;
                $display("FAIL idle_pclk cyc=%0d got %b want %b", i, pclk, exp_pclk);
            end
            n_tests++;
            if ({frame_done, vs, hs, data, rd_en, h_addr, v_addr, state} !== 21'd0) begin
                n_fail++;
                $display("FAIL idle_outputs cyc=%0d got %h want 0", i,
                         {frame_done, vs, hs, data, rd_en, h_addr, v_addr, state});
            end
            exp_pclk = ~exp_pclk;
        end
    endtask

    task automatic check_frame(input string name, input int drop_cycle, input logic [2:0] next_state);
        int n, line, tick, ph, rd_cnt, hs_cyc, vs_cyc;
        logic [2:0]  e_state, e_h, e_v;
        logic        e_vs, e_hs, e_rd;
        logic [7:0]  e_data;
        logic [15:0] px;
        n = 0;
        while (state !== 3'd1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (state !== 3'd1) begin
            n_fail++;
            $display("FAIL %s_start state=%0d want 1", name, state);
        end
        rd_cnt = 0; hs_cyc = 0; vs_cyc = 0;
        for (int c = 0; c < 144; c++) begin
            line = c / 24;
            tick = (c % 24) / 2;
            ph   = c % 2;
            e_state = (line == 0) ? 3'd1 : (line == 1) ? 3'd2 : (line <= 4) ? 3'd3 : 3'd4;
            e_vs = (line == 0);
            e_hs = (line >= 2 && line <= 4 && tick < 8);
            px   = 16'hA0B0 + 16'((line - 2) * 8 + tick / 2);
            e_data = !e_hs ? 8'h00 : (tick % 2 == 0) ? px[15:8] : px[7:0];
            e_rd = (ph == 0) && ((line >= 2 && line <= 4 && (tick == 1 || tick == 3 || tick == 5)) ||
                                 (line >= 1 && line <= 3 && tick == 11));
            e_h  = (tick == 11) ? 3'd0 : 3'((tick + 1) / 2);
            e_v  = (tick == 11) ? 3'(line - 1) : 3'(line - 2);
            n_tests++;
            if ({pclk, vs, hs, state} !== {1'(ph), e_vs, e_hs, e_state}) begin
                n_fail++;
                $display("FAIL %s_ctrl c=%0d got pclk/vs/hs/st=%b%b%b/%0d want %b%b%b/%0d", name, c,
                         pclk, vs, hs, state, 1'(ph), e_vs, e_hs, e_state);
            end
            n_tests++;
            if (data !== e_data) begin
                n_fail++;
                $display("FAIL %s_data c=%0d got %h want %h", name, c, data, e_data);
            end
            n_tests++;
            if (e_rd ? ({rd_en, h_addr, v_addr} !== {1'b1, e_h, e_v}) : (rd_en !== 1'b0)) begin
                n_fail++;
                $display("FAIL %s_fetch c=%0d got rd/h/v=%b/%0d/%0d want %b/%0d/%0d", name, c,
                         rd_en, h_addr, v_addr, e_rd, e_h, e_v);
            end
            if (c > 0) begin
                n_tests++;
                if (frame_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_done_early c=%0d got %b want 0", name, c, frame_done);
                end
            end
            rd_cnt += int'(rd_en);
            hs_cyc += int'(hs);
            vs_cyc += int'(vs);
            if (c == drop_cycle) i_enable = 1'b0;
            @(negedge clk);
        end
        n_tests++;
        if ({frame_done, state} !== {1'b1, next_state}) begin
            n_fail++;
            $display("FAIL %s_end got done/st=%b/%0d want 1/%0d", name, frame_done, state, next_state);
        end
        n_tests++;
        if (rd_cnt != 12) begin
            n_fail++;
            $display("FAIL %s_rd_count got %0d want 12", name, rd_cnt);
        end
        n_tests++;
        if (hs_cyc != 48 || vs_cyc != 24) begin
            n_fail++;
            $display("FAIL %s_sync_len got hs=%0d vs=%0d want 48 24", name, hs_cyc, vs_cyc);
        end
    endtask

    task automatic test_back_to_back();
        i_enable = 1'b1;
        check_frame("frame1", -1, 3'd1);
        check_frame("frame2", 60, 3'd0);
    endtask

    task automatic test_enable_drop();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_tests++;
            if ({frame_done, state} !== 4'd0) begin
                n_fail++;
                $display("FAIL drop_idle cyc=%0d got done/st=%b/%0d want 0/0", i, frame_done, state);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        i_enable = 1'b1;
        n = 0;
        while (state !== 3'd1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (80) @(negedge clk);
        n_tests++;
        if ({state, hs, data} !== {3'd3, 1'b1, 8'hA0}) begin
            n_fail++;
            $display("FAIL mid_pre got st/hs/data=%0d/%b/%h want 3/1/a0", state, hs, data);
        end
        i_reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++;
            if ({pclk, frame_done, vs, hs, data, rd_en, h_addr, v_addr, state} !== 22'd0) begin
                n_fail++;
                $display("FAIL mid_reset cyc=%0d got %h want 0", i,
                         {pclk, frame_done, vs, hs, data, rd_en, h_addr, v_addr, state});
            end
        end
        i_reset = 1'b0;
        check_frame("restart", -1, 3'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        i_enable = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
